// File: rtl/rgb_stream_pkg.sv
// rtl/rgb_stream_pkg.sv - shared types and defaults for the rgb stream transmitter
package rgb_stream_pkg;

    localparam int DEF_DATA_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/rgb_fifo.sv
// rtl/rgb_fifo.sv - pixel load fifo with count, full/empty and sticky overflow
module rgb_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pull;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr && !full;
    assign pull    = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // a write while full is dropped even if a pop frees a slot this same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pull) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pull})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr && full) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_stream_tx.sv
// rtl/rgb_stream_tx.sv - frame-sized raster pixel stream source on a busy/vld handshake
module rgb_stream_tx
    import rgb_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pix_wr,
    input  logic [DATA_W-1:0]        i_pix_data,
    output logic                     o_pix_full,
    output logic                     o_pix_ovf,
    input  logic                     i_frame_start,
    input  logic                     o_rgb_busy,
    output logic                     o_rgb_vld,
    output logic [DATA_W-1:0]        o_rgb_data,
    output logic [$clog2(IMG_W)-1:0] o_col,
    output logic [$clog2(IMG_H)-1:0] o_row,
    output logic                     o_active,
    output logic                     o_frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int PIX_N = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(PIX_N + 1);

    localparam logic [CNT_W-1:0] PIX_CNT  = CNT_W'(PIX_N);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  load_left;
    logic [DATA_W-1:0] head;
    logic              fifo_empty;
    logic              xfer;
    logic              load;
    logic              start_go;

    rgb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr      (i_pix_wr),
        .wr_data (i_pix_data),
        .pop     (load),
        .rd_data (head),
        .full    (o_pix_full),
        .empty   (fifo_empty),
        .ovf     (o_pix_ovf)
    );

    assign xfer     = o_rgb_vld && !o_rgb_busy;
    assign start_go = (state == IDLE) && i_frame_start;
    // load_left counts loads, not transfers, so the register never fetches past the frame
    assign load     = (state == STREAM) && !fifo_empty && (load_left != '0)
                      && (!o_rgb_vld || xfer);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_active     = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (i_frame_start) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                o_active = 1'b1;
                if (xfer && (remaining == CNT_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // col/row advance on transfer so they always name the pixel now in the register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            remaining  <= '0;
            load_left  <= '0;
            o_col      <= '0;
            o_row      <= '0;
            o_rgb_vld  <= 1'b0;
            o_rgb_data <= '0;
        end else begin
            if (start_go) begin
                remaining <= PIX_CNT;
                load_left <= PIX_CNT;
                o_col     <= '0;
                o_row     <= '0;
            end else begin
                if (xfer) begin
                    remaining <= remaining - 1'b1;
                    if (o_col == COL_LAST) begin
                        o_col <= '0;
                        o_row <= (o_row == ROW_LAST) ? '0 : o_row + 1'b1;
                    end else begin
                        o_col <= o_col + 1'b1;
                    end
                end
                if (load) begin
                    load_left <= load_left - 1'b1;
                end
            end
            if (load) begin
                o_rgb_vld  <= 1'b1;
                o_rgb_data <= head;
            end else if (xfer) begin
                o_rgb_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_stream_tx.sv
// tb/tb_rgb_stream_tx.sv - scoreboard bench for rgb_stream_tx
module tb_rgb_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [23:0] wdata;
    logic        full;
    logic        ovf;
    logic        start;
    logic        busy;
    logic        vld;
    logic [23:0] rdata;
    logic [2:0]  col;
    logic [2:0]  row;
    logic        active;
    logic        done;

    int          checks   = 0;
    int          errors   = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          idx      = 0;
    int          cyc      = 0;
    int          last_cyc = 0;
    bit          rate_chk = 0;
    bit          done_pend = 0;
    bit          done_chk2 = 0;
    logic [23:0] exp_q[$];

    rgb_stream_tx #(
        .DATA_W (24),
        .DEPTH  (16),
        .IMG_W  (8),
        .IMG_H  (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_wr      (wr),
        .i_pix_data    (wdata),
        .o_pix_full    (full),
        .o_pix_ovf     (ovf),
        .i_frame_start (start),
        .o_rgb_busy    (busy),
        .o_rgb_vld     (vld),
        .o_rgb_data    (rdata),
        .o_col         (col),
        .o_row         (row),
        .o_active      (active),
        .o_frame_done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // scoreboard side: every accepted transfer is popped and compared at the negedge before it
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            idx       = 0;
            done_pend = 0;
            done_chk2 = 0;
        end else begin
            if (done_pend) begin
                chk("done_pulse", {31'd0, done}, 1);
                chk("active_fall", {31'd0, active}, 0);
                done_pend = 0;
                done_chk2 = 1;
            end else if (done_chk2) begin
                chk("done_width", {31'd0, done}, 0);
                done_chk2 = 0;
            end else if (done) begin
                chk("done_spurious", 1, 0);
            end
            if (done) done_cnt++;
            if (vld && !busy) begin
                xfer_cnt++;
                if (exp_q.size() == 0) chk("xfer_extra", {8'd0, rdata}, 0);
                else chk("data", {8'd0, rdata}, {8'd0, exp_q.pop_front()});
                chk("col", {29'd0, col}, idx % 8);
                chk("row", {29'd0, row}, idx / 8);
                if (rate_chk && idx > 0) chk("rate", cyc - last_cyc, 1);
                last_cyc = cyc;
                idx++;
                if (idx == 64) begin
                    idx       = 0;
                    done_pend = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr       = 1'b0;
        wdata    = '0;
        start    = 1'b0;
        busy     = 1'b0;
        rate_chk = 0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_pix(input logic [23:0] d, input bit keep);
        wr    = 1'b1;
        wdata = d;
        tick();
        wr = 1'b0;
        if (keep) exp_q.push_back(d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int k = 0;
        while (xfer_cnt < target && k < budget) begin
            tick();
            k++;
        end
        if (xfer_cnt < target) chk("xfer_timeout", xfer_cnt, target);
        tick();
    endtask

    // preload 16, start, idle one edge, then stream the rest in at one per clock
    task automatic run_frame(input logic [23:0] base, input int total);
        int x0 = xfer_cnt;
        for (int i = 1; i <= 16; i++) write_pix(base + 24'(i), 1);
        pulse_start();
        tick();
        for (int i = 17; i <= total; i++) write_pix(base + 24'(i), 1);
        wait_xfers(x0 + 64, 200);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int d0;
        bit found;

        // reset state
        do_reset();
        chk("rst_vld", {31'd0, vld}, 0);
        chk("rst_data", {8'd0, rdata}, 0);
        chk("rst_col", {29'd0, col}, 0);
        chk("rst_row", {29'd0, row}, 0);
        chk("rst_active", {31'd0, active}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_full", {31'd0, full}, 0);

        // full-rate frame
        do_reset();
        rate_chk = 1;
        run_frame(24'h000000, 64);
        rate_chk = 0;
        chk("fr_active_low", {31'd0, active}, 0);
        chk("fr_ovf", {31'd0, ovf}, 0);
        chk("fr_q_empty", exp_q.size(), 0);

        // backpressure hold on the (2,0) pixel
        do_reset();
        for (int i = 0; i < 16; i++) write_pix((i == 2) ? 24'h123456 : 24'h200 + 24'(i), 1);
        pulse_start();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (vld && col == 3'd2) found = 1;
        end
        chk("bp_sync", {31'd0, found}, 1);
        busy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_vld", {31'd0, vld}, 1);
            chk("bp_data", {8'd0, rdata}, 32'h123456);
            chk("bp_col", {29'd0, col}, 2);
            chk("bp_row", {29'd0, row}, 0);
            tick();
        end
        x0 = xfer_cnt;
        busy = 1'b0;
        tick();
        chk("bp_xfer", xfer_cnt - x0, 1);
        @(negedge clk);
        chk("bp_next_vld", {31'd0, vld}, 1);
        chk("bp_next_col", {29'd0, col}, 3);
        tick();

        // overflow with no frame running
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_pix(24'h300 + 24'(i), 1);
            if (i == 14) chk("ovf_not_full15", {31'd0, full}, 0);
        end
        chk("ovf_full16", {31'd0, full}, 1);
        chk("ovf_clear16", {31'd0, ovf}, 0);
        write_pix(24'hDEAD00, 0);
        chk("ovf_set", {31'd0, ovf}, 1);
        chk("ovf_still_full", {31'd0, full}, 1);
        x0 = xfer_cnt;
        pulse_start();
        wait_xfers(x0 + 16, 60);
        repeat (4) tick();
        chk("ovf_starve_vld", {31'd0, vld}, 0);
        chk("ovf_starve_active", {31'd0, active}, 1);
        chk("ovf_sticky", {31'd0, ovf}, 1);

        // starvation and ignored second start
        do_reset();
        d0 = done_cnt;
        pulse_start();
        repeat (3) tick();
        chk("st_vld0", {31'd0, vld}, 0);
        chk("st_active", {31'd0, active}, 1);
        x0 = xfer_cnt;
        write_pix(24'hABCDEF, 1);
        chk("st_lat1", {31'd0, vld}, 0);
        tick();
        chk("st_lat2_vld", {31'd0, vld}, 1);
        chk("st_lat2_data", {8'd0, rdata}, 32'hABCDEF);
        pulse_start();
        for (int i = 1; i < 64; i++) write_pix(24'h400 + 24'(i), 1);
        wait_xfers(x0 + 64, 200);
        repeat (8) tick();
        chk("st_done_once", done_cnt - d0, 1);
        chk("st_idle", {31'd0, active}, 0);

        // carry-over of pixels 65..70 into the next frame
        do_reset();
        run_frame(24'h500000, 70);
        repeat (3) tick();
        chk("co_no_extra", {31'd0, vld}, 0);
        chk("co_left", exp_q.size(), 6);
        x0 = xfer_cnt;
        pulse_start();
        wait_xfers(x0 + 6, 40);
        chk("co_q_empty", exp_q.size(), 0);

        // reset in the middle of a frame
        do_reset();
        x0 = xfer_cnt;
        for (int i = 1; i <= 16; i++) write_pix(24'h600000 + 24'(i), 1);
        pulse_start();
        while (xfer_cnt < x0 + 5) tick();
        rst = 1'b1;
        #2;
        chk("mr_vld", {31'd0, vld}, 0);
        chk("mr_data", {8'd0, rdata}, 0);
        chk("mr_col", {29'd0, col}, 0);
        chk("mr_row", {29'd0, row}, 0);
        chk("mr_active", {31'd0, active}, 0);
        chk("mr_full", {31'd0, full}, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        run_frame(24'h700000, 64);
        chk("mr_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_stream_tx.md
Name: rgb_stream_tx

Overview:
Pixel-stream transmitter that drives the busy/vld/data input stream of a DC_Filter instance (the filter's i_rgb_* side). Pixels are loaded through a simple write port into an internal FIFO. On a frame start, exactly IMG_W*IMG_H pixels are emitted on a busy/vld handshake in raster order, and one frame-done pulse follows the last transfer. The block is used in cosim benches and in the on-chip feed path ahead of the filter.

Parameters:
DATA_W, 24, pixel width (R,G,B 8 bits each)
DEPTH, 16, FIFO entries, power of 2, at least 2
IMG_W, 8, pixels per row
IMG_H, 8, rows per frame

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_pix_wr  in  1  write strobe for the FIFO load port
i_pix_data  in  DATA_W  pixel to load
o_pix_full  out  1  FIFO full
o_pix_ovf  out  1  sticky overflow; set when a write arrives while full
i_frame_start  in  1  one-cycle start pulse
o_rgb_busy  in  1  downstream not ready (driven by the filter's i_rgb_busy)
o_rgb_vld  out  1  output valid
o_rgb_data  out  DATA_W  output pixel
o_col  out  $clog2(IMG_W)  column index of the current o_rgb_data
o_row  out  $clog2(IMG_H)  row index of the current o_rgb_data
o_active  out  1  high while in STREAM state
o_frame_done  out  1  one-cycle pulse after the last pixel transfers

Behaviour:
- Reset (async assert, sync release), all values 0:
  - o_rgb_vld, o_rgb_data, o_col, o_row, o_active, o_frame_done, o_pix_ovf all 0.
  - FIFO empty and o_pix_full=0.
  - FSM goes to IDLE.
- Transfer rule: a transfer occurs on a rising edge where o_rgb_vld=1 and o_rgb_busy=0.
  - While o_rgb_vld=1 and o_rgb_busy=1, o_rgb_data, o_col and o_row must hold stable.
  - o_rgb_vld never drops without a transfer.
- FIFO storage:
  - Write pointer, read pointer and count (width $clog2(DEPTH)+1); pointers wrap modulo DEPTH.
  - o_pix_full = (count == DEPTH), registered-equivalent.
  - A write while full is dropped and sets o_pix_ovf, even if a pop happens in the same cycle.
  - o_pix_ovf clears only on reset.
  - A write and a pop in the same non-full cycle leave count unchanged.
- Output register stage (1 entry):
  - Loads from the FIFO head when in STREAM, the FIFO is not empty, pixels remaining > 0, and the register is empty or transferring this cycle.
  - Back-to-back transfers at 1 pixel/clock are required when the FIFO is non-empty and busy is low.
  - Latency: a pixel written into an empty FIFO while in STREAM appears on o_rgb_vld 2 cycles later (1 cycle FIFO write, 1 cycle output register load).
- FSM:
  - IDLE: o_active=0. On i_frame_start go to STREAM; remaining = IMG_W*IMG_H, col = row = 0.
  - STREAM: o_active=1.
    - Each transfer decrements remaining.
    - col increments and wraps to 0 at IMG_W-1; row increments on the column wrap.
    - When the transfer of the last pixel (remaining==1) occurs, go to DONE.
    - An empty FIFO stalls output (vld=0); no timeout.
  - DONE: o_frame_done=1 for exactly one cycle, then IDLE.
- i_frame_start is ignored in STREAM and DONE.
- Pixels left in the FIFO after a frame stay queued for the next frame. The block never emits more than IMG_W*IMG_H pixels per frame.
- o_col and o_row describe the pixel currently held in the output register.
- FIFO writes are accepted in every state.

Decomposition:
- Shared package rgb_stream_pkg:
  - DATA_W default constant.
  - typedef rgb_t (struct of r, g, b, 8 bits each).
  - FSM state enum tx_state_t {IDLE, STREAM, DONE}.
- One sub-module, rgb_fifo:
  - Parameters DATA_W and DEPTH; synchronous write/pop with count, full and empty.
  - Instantiated once. The FSM, output register and counters stay in rgb_stream_tx.

Test Plan:
- Reset mid-stream: assert i_rst after 5 of 64 transfers. All outputs go to 0 immediately, the FIFO empties, and a following i_frame_start streams 64 pixels from new data.
- Full-rate frame: preload 16 pixels 0x000001..0x000010, pulse start, hold busy=0, keep writing 1/clk with values through 0x000040. Required response: 64 consecutive transfers in order, (col,row) runs (0,0)..(7,7), then o_frame_done high 1 cycle after the 64th transfer, and o_active then falls.
- Backpressure: busy=1 for 3 cycles while vld=1 with data 0x123456 at (2,0). Data, col and row hold; the transfer occurs on the first edge with busy=0, and the next pixel follows on the next cycle.
- Overflow: write 17 pixels with no frame started. o_pix_full goes high after the 16th write, the 17th write is dropped, o_pix_ovf=1, and the 16 stored values emerge in order on the next frame.
- Starvation and start-ignore: start a frame with the FIFO empty. vld stays 0; one write of 0xABCDEF appears on o_rgb_data 2 cycles later. A second i_frame_start during STREAM changes nothing: frame length stays 64 and o_frame_done pulses once.
- Carry-over: preload 70 pixels across two frames. Frame 1 emits exactly 64; pixels 65-70 are emitted first in frame 2 at (0,0)..(5,0).
